// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller and its environment: request/mask in,
// mux select/sample path, and the packed-word valid/ready handshake out.
interface mux_scan_ctrl_if #(
  parameter int NUM_CH = 6,
  parameter int SEL_W  = 3
);
  logic              start;
  logic [NUM_CH-1:0] ch_mask;
  logic [SEL_W-1:0]  sel;
  logic              mux_lsb;
  logic              busy;
  logic [NUM_CH-1:0] scan_word;
  logic              scan_valid;
  logic              scan_ready;
  logic              start_err;

  modport master (
    output start, ch_mask, mux_lsb, scan_ready,
    input  sel, busy, scan_word, scan_valid, start_err
  );

  modport slave (
    input  start, ch_mask, mux_lsb, scan_ready,
    output sel, busy, scan_word, scan_valid, start_err
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the mux_6to1 select path: walks the enabled channels,
// settles, samples the mux LSB of each and hands the packed word downstream.
module mux_scan_ctrl #(
  parameter int NUM_CH   = 6,
  parameter int SEL_W    = 3,
  parameter int SETTLE   = 1,
  parameter int PARK_SEL = 7
) (
  input logic             clk,
  input logic             reset,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_OUT} state_t;

  localparam state_t         CH_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [3:0]     CNT_LOAD = 4'(SETTLE);
  localparam logic [SEL_W-1:0] PARK   = SEL_W'(PARK_SEL);

  state_t            state_q, state_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic [3:0]        cnt_q, cnt_nxt;
  logic [NUM_CH-1:0] mask_q, mask_nxt;
  logic [NUM_CH-1:0] word_q, word_nxt;
  logic              valid_q, valid_nxt;
  logic              busy_q, busy_nxt;
  logic              err_q, err_nxt;

  logic              first_found, next_found;
  logic [SEL_W-1:0]  first_ch, next_ch;
  logic              handshake;

  // Lowest channel of the incoming mask, and next enabled channel above sel.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = SEL_W'(i);
      end
      if (mask_q[i] && (SEL_W'(i) > sel_q)) begin
        next_found = 1'b1;
        next_ch    = SEL_W'(i);
      end
    end
  end

  assign handshake = (state_q == S_OUT) && valid_q && bus.scan_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= PARK;
      cnt_q   <= '0;
      mask_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      cnt_q   <= cnt_nxt;
      mask_q  <= mask_nxt;
      word_q  <= word_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_nxt = first_found ? CH_STATE : S_OUT;
      S_SETTLE: if (cnt_q <= 4'd1) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = next_found ? CH_STATE : S_OUT;
      S_OUT: begin
        if (handshake) begin
          if (bus.start) state_nxt = first_found ? CH_STATE : S_OUT;
          else           state_nxt = S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // An empty mask lands in OUT with valid low; valid rises one edge later.
  always_comb begin
    sel_nxt   = sel_q;
    cnt_nxt   = cnt_q;
    mask_nxt  = mask_q;
    word_nxt  = word_q;
    valid_nxt = valid_q;
    busy_nxt  = busy_q;
    err_nxt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_nxt = bus.ch_mask;
          word_nxt = '0;
          busy_nxt = 1'b1;
          sel_nxt  = first_found ? first_ch : PARK;
          cnt_nxt  = CNT_LOAD;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt_q - 4'd1;
        err_nxt = bus.start;
      end
      S_SAMPLE: begin
        err_nxt = bus.start;
        for (int i = 0; i < NUM_CH; i++) begin
          if (SEL_W'(i) == sel_q) word_nxt[i] = bus.mux_lsb;
        end
        if (next_found) begin
          sel_nxt = next_ch;
          cnt_nxt = CNT_LOAD;
        end else begin
          sel_nxt   = PARK;
          valid_nxt = 1'b1;
        end
      end
      S_OUT: begin
        if (!valid_q) valid_nxt = 1'b1;
        if (handshake) begin
          valid_nxt = 1'b0;
          if (bus.start) begin
            mask_nxt = bus.ch_mask;
            word_nxt = '0;
            sel_nxt  = first_found ? first_ch : PARK;
            cnt_nxt  = CNT_LOAD;
          end else begin
            busy_nxt = 1'b0;
          end
        end else begin
          err_nxt = bus.start;
        end
      end
      default: ;
    endcase
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.scan_word  = word_q;
  assign bus.scan_valid = valid_q;
  assign bus.start_err  = err_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl with a behavioural mux_6to1
// model on the select path; each scenario task checks its own results.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] data_in;
  int         n_checks = 0;
  int         n_pass = 0;

  mux_scan_ctrl_if #(.NUM_CH(6), .SEL_W(3)) bus ();

  mux_scan_ctrl #(.NUM_CH(6), .SEL_W(3), .SETTLE(1), .PARK_SEL(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mux_lsb = (bus.sel < 3'd6) ? data_in[bus.sel] : 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.ch_mask = '0;
    bus.scan_ready = 1'b0;
    data_in = '0;
    tick();
    tick();
    n_checks++; if (bus.sel !== 3'd7) $display("[TB] FAIL reset_sel: got %0d want 7", bus.sel); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b0) $display("[TB] FAIL reset_word: got %b want 000000", bus.scan_word); else n_pass++;
    n_checks++; if (bus.start_err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", bus.start_err); else n_pass++;
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_full_scan();
    data_in = 6'b101101;
    bus.ch_mask = 6'b111111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ch_mask = 6'b000000;
    for (int j = 0; j < 12; j++) begin
      n_checks++; if (bus.sel !== 3'(j / 2)) $display("[TB] FAIL full_sel[%0d]: got %0d want %0d", j, bus.sel, j / 2); else n_pass++;
      n_checks++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL full_early_valid[%0d]: got %b want 0", j, bus.scan_valid); else n_pass++;
      tick();
    end
    n_checks++; if (bus.scan_valid !== 1'b1) $display("[TB] FAIL full_valid: got %b want 1", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b101101) $display("[TB] FAIL full_word: got %b want 101101", bus.scan_word); else n_pass++;
    n_checks++; if (bus.sel !== 3'd7) $display("[TB] FAIL full_park: got %0d want 7", bus.sel); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL full_busy: got %b want 1", bus.busy); else n_pass++;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
    n_checks++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL full_hs_valid: got %b want 0", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL full_hs_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b101101) $display("[TB] FAIL full_hs_word: got %b want 101101", bus.scan_word); else n_pass++;
  endtask

  task automatic test_sparse_mask();
    logic [2:0] exp_sel [4] = '{3'd1, 3'd1, 3'd4, 3'd4};
    data_in = 6'b111111;
    bus.ch_mask = 6'b010010;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (bus.sel !== exp_sel[j]) $display("[TB] FAIL sparse_sel[%0d]: got %0d want %0d", j, bus.sel, exp_sel[j]); else n_pass++;
      tick();
    end
    n_checks++; if (bus.sel !== 3'd7) $display("[TB] FAIL sparse_park: got %0d want 7", bus.sel); else n_pass++;
    n_checks++; if (bus.scan_valid !== 1'b1) $display("[TB] FAIL sparse_valid: got %b want 1", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b010010) $display("[TB] FAIL sparse_word: got %b want 010010", bus.scan_word); else n_pass++;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
  endtask

  task automatic test_empty_mask();
    data_in = 6'b111111;
    bus.ch_mask = 6'b000000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL empty_valid0: got %b want 0", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b0) $display("[TB] FAIL empty_cleared: got %b want 000000", bus.scan_word); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL empty_busy: got %b want 1", bus.busy); else n_pass++;
    tick();
    n_checks++; if (bus.scan_valid !== 1'b1) $display("[TB] FAIL empty_valid1: got %b want 1", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.sel !== 3'd7) $display("[TB] FAIL empty_sel: got %0d want 7", bus.sel); else n_pass++;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL empty_hs_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_start_err();
    data_in = 6'b000010;
    bus.ch_mask = 6'b000011;
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.start_err !== 1'b1) $display("[TB] FAIL err_settle_pulse: got %b want 1", bus.start_err); else n_pass++;
    n_checks++; if (bus.sel !== 3'd0) $display("[TB] FAIL err_settle_sel: got %0d want 0", bus.sel); else n_pass++;
    tick();
    n_checks++; if (bus.start_err !== 1'b0) $display("[TB] FAIL err_settle_drop: got %b want 0", bus.start_err); else n_pass++;
    n_checks++; if (bus.sel !== 3'd1) $display("[TB] FAIL err_next_sel: got %0d want 1", bus.sel); else n_pass++;
    tick();
    tick();
    n_checks++; if (bus.scan_valid !== 1'b1) $display("[TB] FAIL err_valid: got %b want 1", bus.scan_valid); else n_pass++;
    for (int j = 0; j < 5; j++) begin
      bus.start = (j == 2);
      tick();
      n_checks++; if (bus.start_err !== (j == 2)) $display("[TB] FAIL err_out_pulse[%0d]: got %b want %b", j, bus.start_err, (j == 2)); else n_pass++;
      n_checks++; if (bus.scan_valid !== 1'b1) $display("[TB] FAIL err_out_valid[%0d]: got %b want 1", j, bus.scan_valid); else n_pass++;
      n_checks++; if (bus.scan_word !== 6'b000010) $display("[TB] FAIL err_out_word[%0d]: got %b want 000010", j, bus.scan_word); else n_pass++;
      n_checks++; if (bus.sel !== 3'd7) $display("[TB] FAIL err_out_sel[%0d]: got %0d want 7", j, bus.sel); else n_pass++;
    end
    bus.start = 1'b0;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL err_hs_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_sel [4] = '{3'd3, 3'd3, 3'd5, 3'd5};
    data_in = 6'b111111;
    bus.ch_mask = 6'b000100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.scan_word !== 6'b000100) $display("[TB] FAIL b2b_first_word: got %b want 000100", bus.scan_word); else n_pass++;
    data_in = 6'b101010;
    bus.ch_mask = 6'b101000;
    bus.start = 1'b1;
    bus.scan_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.scan_ready = 1'b0;
    n_checks++; if (bus.scan_word !== 6'b0) $display("[TB] FAIL b2b_cleared: got %b want 000000", bus.scan_word); else n_pass++;
    n_checks++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL b2b_valid_drop: got %b want 0", bus.scan_valid); else n_pass++;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (bus.sel !== exp_sel[j]) $display("[TB] FAIL b2b_sel[%0d]: got %0d want %0d", j, bus.sel, exp_sel[j]); else n_pass++;
      n_checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_busy[%0d]: got %b want 1", j, bus.busy); else n_pass++;
      tick();
    end
    n_checks++; if (bus.scan_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b want 1", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b101000) $display("[TB] FAIL b2b_word: got %b want 101000", bus.scan_word); else n_pass++;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    data_in = 6'b101101;
    bus.ch_mask = 6'b111111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    n_checks++; if (bus.sel !== 3'd3) $display("[TB] FAIL mid_pre_sel: got %0d want 3", bus.sel); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.sel !== 3'd7) $display("[TB] FAIL mid_sel: got %0d want 7", bus.sel); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL mid_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.scan_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b want 0", bus.scan_valid); else n_pass++;
    n_checks++; if (bus.scan_word !== 6'b0) $display("[TB] FAIL mid_word: got %b want 000000", bus.scan_word); else n_pass++;
    tick();
    #2 reset = 1'b0;
    tick();
    test_full_scan();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_empty_mask();
    test_start_err();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
